muldiv_ctrl: RTL and testbench

M-extension execute-stage controller for the RV32IM core. It accepts one MUL/DIV/REM request at a time from the EX stage and sequences two resources:
- the internal one-cycle 32x32 multiplier (`multiplier_1c` instance), with its `sign_sel` driven from `funct3`;
- an internal 32-iteration restoring divider.

It returns a registered 32-bit result with a one-cycle `done` pulse, and exposes `busy` so the hazard unit can stall the pipeline.

---
 rtl/muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M execute-stage sequencer for a one-cycle multiplier and a 32-step restoring divider
module multiplier_1c (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sign_sel,
  output logic [63:0] product
);
  logic signed [63:0] a_x;
  logic signed [63:0] b_x;
  always_comb begin
    a_x = {{32{a[31] & (sign_sel != 2'b10)}}, a};
    b_x = {{32{b[31] & (sign_sel == 2'b00)}}, b};
    product = a_x * b_x;
  end
endmodule

module muldiv_ctrl #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
  logic [2:0]  f_q, f_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  sign_sel;
  logic [63:0] product;
  logic [32:0] rem_s;
  logic [31:0] rem_n, quo_n, abs_a, abs_b, special, q_fix, r_fix;
  logic        ge, div0, ovf;

  multiplier_1c u_mul (.a(a_q), .b(b_q), .sign_sel(sign_sel), .product(product));

  always_comb begin
    sign_sel = f_q[1] ? (f_q[0] ? 2'b10 : 2'b01) : 2'b00;
    abs_a    = (!funct3[0] && opA[31]) ? -opA : opA;
    abs_b    = (!funct3[0] && opB[31]) ? -opB : opB;
    div0     = opB == 32'd0;
    ovf      = !funct3[0] && opA == 32'h8000_0000 && opB == 32'hFFFF_FFFF;
    special  = div0 ? (funct3[1] ? opA : 32'hFFFF_FFFF) : (funct3[1] ? 32'd0 : 32'h8000_0000);
    // remainder is always below the divisor after a step, so 32 bits hold it
    rem_s    = {rem_q, quo_q[31]};
    ge       = rem_s >= {1'b0, dvs_q};
    rem_n    = ge ? rem_s[31:0] - dvs_q : rem_s[31:0];
    quo_n    = {quo_q[30:0], ge};
    q_fix    = (!f_q[0] && (a_q[31] ^ b_q[31])) ? -quo_n : quo_n;
    r_fix    = (!f_q[0] && a_q[31]) ? -rem_n : rem_n;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          a_d = opA;
          b_d = opB;
          f_d = funct3;
          if (!funct3[2]) begin
            state_d = S_MUL;
          end else if (div0 || ovf) begin
            result_d = special;
            state_d  = S_DONE;
          end else begin
            quo_d   = abs_a;
            rem_d   = 32'd0;
            dvs_d   = abs_b;
            cnt_d   = 6'd0;
            state_d = S_DIV;
          end
        end
        S_MUL: begin
          result_d = (f_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
          state_d  = S_DONE;
        end
        S_DIV: begin
          quo_d = quo_n;
          rem_d = rem_n;
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == 6'(DIV_STEPS)) begin
            result_d = f_q[1] ? r_fix : q_fix;
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready  = state_q == S_IDLE;
  assign busy   = state_q == S_MUL || state_q == S_DIV;
  assign done   = state_q == S_DONE;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl results, latency, flush and reset
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;
  int          vectors = 0;
  int          errors = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .opA(opA), .opB(opB),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bc, output logic rdy);
    @(negedge clk);
    start = 1'b1; funct3 = f; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bc = 0;
    while (!done && lat < 100) begin
      bc += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
    rdy = ready;
  endtask

  task automatic test_reset;
    start = 1'b1; funct3 = 3'b100; opA = 32'd9; opB = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ready=%b busy=%b done=%b, need 1 0 0", ready, busy, done);
    end
    vectors++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL reset_result: got %h need 00000000", result);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0]  f [4]  = '{3'b000, 3'b011, 3'b010, 3'b001};
    logic [31:0] e [4]  = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] res;
    int lat, bc;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc, rdy);
      vectors++;
      if (res !== e[i]) begin
        errors++; $display("FAIL mul_f%b: got %h need %h", f[i], res, e[i]);
      end
      vectors++;
      if (lat !== 2 || bc !== 1) begin
        errors++; $display("FAIL mul_timing_f%b: latency %0d busy %0d, need 2 and 1", f[i], lat, bc);
      end
    end
    vectors++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL mul_ready_after: got %b need 1", rdy);
    end
  endtask

  task automatic test_div_signed;
    logic [31:0] res;
    int lat, bc;
    logic rdy;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg7_2: got %h need FFFFFFFD", res);
    end
    vectors++;
    if (lat !== 33 || bc !== 32) begin
      errors++; $display("FAIL div_timing: latency %0d busy %0d, need 33 and 32", lat, bc);
    end
    vectors++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL div_ready_after: got %b need 1", rdy);
    end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rem_neg7_2: got %h need FFFFFFFF", res);
    end
    vectors++;
    if (lat !== 33 || bc !== 32) begin
      errors++; $display("FAIL rem_timing: latency %0d busy %0d, need 33 and 32", lat, bc);
    end
    run_op(3'b100, 32'd100, 32'hFFFF_FFF9, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'hFFFF_FFF2) begin
      errors++; $display("FAIL div_100_neg7: got %h need FFFFFFF2", res);
    end
  endtask

  task automatic test_div_unsigned;
    logic [31:0] res;
    int lat, bc;
    logic rdy;
    run_op(3'b101, 32'd100, 32'd7, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'd14) begin
      errors++; $display("FAIL divu_100_7: got %0d need 14", res);
    end
    run_op(3'b111, 32'd100, 32'd7, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'd2) begin
      errors++; $display("FAIL remu_100_7: got %0d need 2", res);
    end
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'h7FFF_FFFC) begin
      errors++; $display("FAIL divu_big: got %h need 7FFFFFFC", res);
    end
  endtask

  task automatic test_special;
    logic [2:0]  f [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int lat, bc;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], res, lat, bc, rdy);
      vectors++;
      if (res !== e[i]) begin
        errors++; $display("FAIL special_%0d: got %h need %h", i, res, e[i]);
      end
      vectors++;
      if (lat !== 1 || bc !== 0) begin
        errors++; $display("FAIL special_timing_%0d: latency %0d busy %0d, need 1 and 0", i, lat, bc);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat, bc, seen;
    logic rdy;
    run_op(3'b101, 32'd100, 32'd7, res, lat, bc, rdy);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; opA = 32'd1000; opB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_pre_busy: got %b need 1", busy);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_idle: ready=%b busy=%b done=%b, need 1 0 0", ready, busy, done);
    end
    vectors++;
    if (result !== 32'd14) begin
      errors++; $display("FAIL flush_result: got %0d need 14", result);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      seen += int'(done);
    end
    vectors++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_no_done: done seen %0d times, need 0", seen);
    end
    @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    vectors++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL flush_start_ignored: ready %b need 1", ready);
    end
    run_op(3'b000, 32'd6, 32'd7, res, lat, bc, rdy);
    vectors++;
    if (res !== 32'd42 || lat !== 2) begin
      errors++; $display("FAIL flush_then_mul: got %0d latency %0d, need 42 latency 2", res, lat);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; opA = 32'd1000; opB = 32'd3;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #3;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre_busy: got %b need 1", busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL rst_mid_async: ready=%b busy=%b done=%b result=%h, need 1 0 0 0", ready, busy, done, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_start_held: ready=%b busy=%b, need 1 0", ready, busy);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div_signed;
    test_div_unsigned;
    test_special;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
